// File: rtl/keccak_perm_arbiter.sv
// Round-robin arbiter/sequencer sharing one Keccak-f[1600] datapath among NUM_REQ requesters.
// Outputs decode registered state only; no input-to-output combinational path.
module keccak_perm_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned NUM_ROUNDS = 24,
  localparam int unsigned IDX_W     = $clog2(NUM_REQ),
  localparam int unsigned CNT_W     = $clog2(NUM_ROUNDS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               ready_dp_i,
  output logic               start_dp_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               busy_o,
  output logic               keccak_intr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DONE
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_gnt_idx, w_gnt_idx_nxt;
  logic [IDX_W-1:0]   r_last_idx, w_last_idx_nxt;
  logic [IDX_W-1:0]   w_cand;
  logic [IDX_W-1:0]   w_winner;
  logic               w_found;
  logic [NUM_REQ-1:0] w_onehot;

  // Scan starts one past the previous owner and wraps, giving round-robin order.
  always_comb begin
    w_cand   = '0;
    w_winner = '0;
    w_found  = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_cand = IDX_W'((32'(r_last_idx) + i) % NUM_REQ);
      if (!w_found && req_i[w_cand]) begin
        w_winner = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_gnt_idx_nxt  = r_gnt_idx;
    w_last_idx_nxt = r_last_idx;
    case (r_state)
      S_IDLE: begin
        if (w_found && ready_dp_i) begin
          w_gnt_idx_nxt = w_winner;
          w_state_nxt   = S_START;
        end
      end
      S_START: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (r_cnt == CNT_W'(NUM_ROUNDS - 1)) begin
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        w_last_idx_nxt = r_gnt_idx;
        w_state_nxt    = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_gnt_idx  <= '0;
      r_last_idx <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_gnt_idx  <= w_gnt_idx_nxt;
      r_last_idx <= w_last_idx_nxt;
    end
  end

  assign w_onehot    = NUM_REQ'(1) << r_gnt_idx;
  assign start_dp_o  = (r_state == S_START);
  assign gnt_o       = (r_state != S_IDLE) ? w_onehot : '0;
  assign done_o      = (r_state == S_DONE) ? w_onehot : '0;
  assign gnt_idx_o   = r_gnt_idx;
  assign busy_o      = (r_state != S_IDLE);
  assign keccak_intr = (r_state == S_DONE);

endmodule

// File: tb/tb_keccak_perm_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline model.
module tb_keccak_perm_arbiter;

  localparam int unsigned NR   = 3;
  localparam int unsigned NRND = 24;
  localparam int unsigned IW   = $clog2(NR);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [NR-1:0] req_i = '0;
  logic          ready_dp_i = 1'b0;
  logic          start_dp_o;
  logic [NR-1:0] gnt_o;
  logic [IW-1:0] gnt_idx_o;
  logic [NR-1:0] done_o;
  logic          busy_o;
  logic          keccak_intr;

  keccak_perm_arbiter #(.NUM_REQ(NR), .NUM_ROUNDS(NRND)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (req_i),
    .ready_dp_i (ready_dp_i),
    .start_dp_o (start_dp_o),
    .gnt_o      (gnt_o),
    .gnt_idx_o  (gnt_idx_o),
    .done_o     (done_o),
    .busy_o     (busy_o),
    .keccak_intr(keccak_intr)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: m_age is the cycle number within an operation (0 = idle,
  // 1 = start, N+2 = completion), m_owner the granted requester.
  int            m_age   = 0;
  logic [IW-1:0] m_owner = '0;
  logic [IW-1:0] m_last  = IW'(NR - 1);

  function automatic logic [IW-1:0] rr_pick(input logic [NR-1:0] req, input logic [IW-1:0] last);
    for (int k = 1; k <= NR; k++) begin
      int c;
      c = (int'(last) + k) % NR;
      if (req[c]) return IW'(c);
    end
    return '0;
  endfunction

  task automatic model_edge(input logic [NR-1:0] req, input logic ready, input logic rst_n);
    if (!rst_n) begin
      m_age   = 0;
      m_owner = '0;
      m_last  = IW'(NR - 1);
    end else if (m_age == 0) begin
      if ((req != '0) && ready) begin
        m_owner = rr_pick(req, m_last);
        m_age   = 1;
      end
    end else if (m_age == NRND + 2) begin
      m_last = m_owner;
      m_age  = 0;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_model();
    logic [NR-1:0] oh;
    oh = NR'(1) << m_owner;
    check_eq("start", 32'(start_dp_o), 32'(m_age == 1));
    check_eq("gnt",   32'(gnt_o),      (m_age != 0) ? 32'(oh) : 32'd0);
    check_eq("idx",   32'(gnt_idx_o),  32'(m_owner));
    check_eq("done",  32'(done_o),     (m_age == NRND + 2) ? 32'(oh) : 32'd0);
    check_eq("busy",  32'(busy_o),     32'(m_age != 0));
    check_eq("intr",  32'(keccak_intr), 32'(m_age == NRND + 2));
  endtask

  // Drive inputs for the current cycle, clock once, then check the new cycle.
  task automatic step(input logic [NR-1:0] req, input logic ready, input logic rst_n);
    req_i      = req;
    ready_dp_i = ready;
    rst_ni     = rst_n;
    model_edge(req, ready, rst_n);
    @(posedge clk_i);
    #1;
    check_model();
  endtask

  int unsigned exp_rr [6] = '{0, 1, 2, 0, 1, 2};
  logic [IW-1:0] got_rr[$];

  initial begin
    // Reset with every request asserted
    step('1, 1'b1, 1'b0);
    step('1, 1'b1, 1'b0);
    check_eq("rst_start", 32'(start_dp_o), 0);
    check_eq("rst_gnt",   32'(gnt_o), 0);
    check_eq("rst_done",  32'(done_o), 0);
    check_eq("rst_busy",  32'(busy_o), 0);
    check_eq("rst_intr",  32'(keccak_intr), 0);
    check_eq("rst_idx",   32'(gnt_idx_o), 0);

    // Single request latency: request sampled in cycle 0
    step(3'b001, 1'b1, 1'b1);
    check_eq("lat_start", 32'(start_dp_o), 1);
    check_eq("lat_gnt1",  32'(gnt_o), 32'b001);
    for (int c = 2; c <= 26; c++) begin
      step(3'b001, 1'b1, 1'b1);
      check_eq("lat_gnt", 32'(gnt_o), 32'b001);
    end
    check_eq("lat_done", 32'(done_o), 32'b001);
    check_eq("lat_intr", 32'(keccak_intr), 1);
    step(3'b000, 1'b1, 1'b1);
    check_eq("lat_busy_off", 32'(busy_o), 0);

    // Round-robin from a fresh reset with all three requesting
    step(3'b000, 1'b1, 1'b0);
    got_rr.delete();
    for (int c = 0; c < 400 && got_rr.size() < 6; c++) begin
      step(3'b111, 1'b1, 1'b1);
      if (start_dp_o) got_rr.push_back(gnt_idx_o);
    end
    check_eq("rr_count", 32'(got_rr.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < got_rr.size()) check_eq("rr_order", 32'(got_rr[i]), exp_rr[i]);
    end
    for (int c = 0; c < 60 && busy_o; c++) step(3'b000, 1'b1, 1'b1);
    check_eq("rr_drain", 32'(busy_o), 0);

    // Datapath not ready for five cycles
    for (int c = 0; c < 5; c++) begin
      step(3'b010, 1'b0, 1'b1);
      check_eq("nr_nostart", 32'(start_dp_o), 0);
    end
    step(3'b010, 1'b1, 1'b1);
    check_eq("nr_start", 32'(start_dp_o), 1);
    check_eq("nr_gnt",   32'(gnt_o), 32'b010);

    // Request dropped from RUN cycle 10 onward; done still at nominal cycle
    for (int c = 1; c <= NRND; c++) step((c <= 10) ? 3'b010 : 3'b000, 1'b1, 1'b1);
    check_eq("drop_nodone", 32'(done_o), 0);
    step(3'b000, 1'b1, 1'b1);
    check_eq("drop_done", 32'(done_o), 32'b010);
    check_eq("drop_intr", 32'(keccak_intr), 1);
    step(3'b000, 1'b1, 1'b1);

    // Reset pulsed in RUN cycle 5
    step(3'b010, 1'b1, 1'b1);
    check_eq("mr_start", 32'(start_dp_o), 1);
    for (int c = 1; c <= 5; c++) step(3'b010, 1'b1, 1'b1);
    step(3'b011, 1'b1, 1'b0);
    check_eq("mr_busy", 32'(busy_o), 0);
    check_eq("mr_done", 32'(done_o), 0);
    check_eq("mr_intr", 32'(keccak_intr), 0);
    step(3'b011, 1'b1, 1'b1);
    check_eq("mr_tie_idx", 32'(gnt_idx_o), 0);
    check_eq("mr_tie_gnt", 32'(gnt_o), 32'b001);
    for (int c = 0; c < 60 && busy_o; c++) step(3'b000, 1'b1, 1'b1);

    // Random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      step(NR'($urandom_range(0, (1 << NR) - 1)),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 299) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/keccak_perm_arbiter.md
# keccak_perm_arbiter

Round-robin arbiter and sequencer that shares one Keccak-f[1600] permutation datapath among `NUM_REQ` requesters, e.g. SHA-3 and SHAKE front-ends. It sits between the requesters and the datapath. It picks one requester, pulses the datapath start, counts the permutation rounds, then returns a per-requester done pulse plus a global interrupt. It also drives the grant index that steers the datapath state-input and state-output muxes.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; legal range 2..8.
- `NUM_ROUNDS`, default 24: cycles the datapath needs per permutation after start; must be ≥1.

Derived widths:
- `IDX_W` = `$clog2(NUM_REQ)`.
- `CNT_W` = `$clog2(NUM_ROUNDS+1)`.

Ports:
- `clk_i`  in  1  clock; all logic on the rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `req_i`  in  NUM_REQ  level request per requester; held high until that requester's `done_o` bit.
- `ready_dp_i`  in  1  datapath idle and able to accept a start.
- `start_dp_o`  out  1  one-cycle start pulse to the datapath.
- `gnt_o`  out  NUM_REQ  one-hot grant; selects the owner of the datapath.
- `gnt_idx_o`  out  IDX_W  binary index of the current or most recent grant; drives the datapath muxes.
- `done_o`  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- `busy_o`  out  1  high whenever the arbiter is not in IDLE.
- `keccak_intr`  out  1  one-cycle interrupt pulse on every completion.

## Operation
FSM states: IDLE, START, RUN, DONE. All outputs are decoded from registered state, so there is no combinational path from any input to any output.

- **IDLE**
  - If `|req_i` and `ready_dp_i`: choose the winner, load `gnt_idx`, go to START.
  - Otherwise stay in IDLE.
  - Winner selection: the first set bit of `req_i` scanning from `(last_idx+1) mod NUM_REQ` upward, with wrap-around.
- **START**
  - `start_dp_o`=1; `counter` is cleared to 0.
  - Always go to RUN.
- **RUN**
  - `counter` increments each cycle.
  - When `counter == NUM_ROUNDS-1`, go to DONE.
  - `ready_dp_i` is ignored.
- **DONE**
  - `done_o[gnt_idx]`=1 and `keccak_intr`=1.
  - `last_idx` <= `gnt_idx`.
  - Always go to IDLE.

Output behaviour by state:
- `gnt_o` = one-hot of `gnt_idx` in START, RUN and DONE; 0 in IDLE.
- `gnt_idx_o` holds its value through IDLE.
- `busy_o` = (state != IDLE).

Request handling:
- `req_i` is sampled only in IDLE.
- Deasserting the granted `req_i` during START, RUN or DONE does not abort the operation; `done_o` still pulses.
- Asserting a new `req_i` in those states has no effect until the next IDLE.

Counter width: `CNT_W` bits. `counter` never exceeds `NUM_ROUNDS-1` and never wraps.

## Timing
- Reset (`rst_ni` low at a clock edge):
  - State goes to IDLE; `counter`=0; `gnt_idx`=0; `last_idx`=`NUM_REQ-1`, so requester 0 wins first.
  - All outputs are 0 in the following cycle.
- Reset asserted mid-operation (START, RUN or DONE) aborts the operation with no `done_o` pulse; the FSM is in IDLE the next cycle.
- Latency, with the request sampled in IDLE at cycle t:
  - `start_dp_o` high in cycle t+1.
  - RUN occupies cycles t+2 .. t+1+NUM_ROUNDS.
  - `done_o` and `keccak_intr` high in cycle t+2+NUM_ROUNDS.
  - Total = `NUM_ROUNDS`+2 cycles from grant decision to done.
- At least one IDLE cycle always separates two operations. Back-to-back throughput is one permutation per `NUM_ROUNDS`+3 cycles.
- A requester must drop `req_i` in the cycle after its `done_o`; `req_i` still high in that IDLE cycle is treated as a new request.
- Requests present while `ready_dp_i`=0 in IDLE: no grant and no state change; the winner is re-evaluated every cycle.
- Fairness: with all `NUM_REQ` requesters continuously requesting, each is granted exactly once every `NUM_REQ` operations.

## Test plan
- **Reset values:** hold `rst_ni`=0 for 2 cycles with `req_i`=all-ones -> `start_dp_o`, `gnt_o`, `done_o`, `busy_o` and `keccak_intr` are all 0, and `gnt_idx_o`=0.
- **Single request latency:** `NUM_ROUNDS`=24; `req_i`=01 and `ready_dp_i`=1 at cycle 0 -> `start_dp_o` at cycle 1, `gnt_o`=01 for cycles 1-26, `done_o`=01 and `keccak_intr` at cycle 26, `busy_o` low at cycle 27.
- **Round-robin:** `NUM_REQ`=3; `req_i`=111 held, each requester re-asserting after its done -> grant order 0,1,2,0,1,2; `gnt_idx_o` sequence 0,1,2,0,1,2.
- **Datapath not ready:** `req_i`=10 with `ready_dp_i`=0 for 5 cycles, then 1 -> no `start_dp_o` during the 5 cycles; start one cycle after `ready_dp_i` rises; `gnt_o`=10.
- **Request drop mid-run:** requester 1 drops `req_i` at RUN cycle 10 -> the run completes and `done_o`=10 pulses at the nominal cycle.
- **Reset mid-run:** pulse `rst_ni`=0 at RUN cycle 5 -> no `done_o` and no `keccak_intr`; IDLE next cycle; requester 0 then wins a tie against requester 1.
